// File: rtl/gshare_bht.sv
// gshare_bht: parametrised branch history table of saturating counters.
// It can be indexed by the PC alone (bimodal) or by the PC XOR a speculative
// global history register (gshare). The GHR shifts in each prediction at
// lookup time and is restored from a pipeline checkpoint on a mispredict.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   predict_valid     fetch lookup strobe (shifts the GHR speculatively)
//   predict_pc        PC being looked up
//   prediction        1 = predict taken (counter MSB)
//   confidence        raw counter at the lookup index
//   pred_ghr          GHR used for this lookup (checkpoint for the pipeline)
//   update_valid      resolve strobe from execute/commit
//   update_pc         PC of the resolved branch
//   update_ghr        checkpoint captured at prediction time
//   actual_taken      resolved direction
//   is_branch         qualifies update_valid
//   mispredict        resolved direction differed from the prediction
//   ghr_out           live GHR (debug)
//   mispredict_count  saturating count of mispredicts
module gshare_bht #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int MODE       = 1,
  parameter int STAT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  predict_valid,
  input  logic [ADDR_WIDTH-1:0] predict_pc,
  output logic                  prediction,
  output logic [CTR_BITS-1:0]   confidence,
  output logic [GHR_BITS-1:0]   pred_ghr,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic [GHR_BITS-1:0]   update_ghr,
  input  logic                  actual_taken,
  input  logic                  is_branch,
  input  logic                  mispredict,
  output logic [GHR_BITS-1:0]   ghr_out,
  output logic [STAT_BITS-1:0]  mispredict_count
);

  localparam int DEPTH = 2 ** INDEX_BITS;
  // Weak not-taken: the value just below the taken threshold.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic [CTR_BITS-1:0]   table_q [DEPTH];
  logic [GHR_BITS-1:0]   ghr_q;
  logic [STAT_BITS-1:0]  mis_count_q;

  logic [INDEX_BITS-1:0] lookup_pc_idx;
  logic [INDEX_BITS-1:0] update_pc_idx;
  logic [INDEX_BITS-1:0] lookup_hist;
  logic [INDEX_BITS-1:0] update_hist;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [CTR_BITS-1:0]   lookup_ctr;
  logic [CTR_BITS-1:0]   update_ctr;
  logic [GHR_BITS-1:0]   spec_ghr;
  logic [GHR_BITS-1:0]   recover_ghr;
  logic                  do_update;
  logic                  recover;
  logic                  unused_pc_bits;

  // Only the word-aligned low PC bits select an entry; the rest alias freely.
  assign lookup_pc_idx = predict_pc[INDEX_BITS+1:2];
  assign update_pc_idx = update_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{predict_pc[ADDR_WIDTH-1:INDEX_BITS+2], predict_pc[1:0],
                            update_pc[ADDR_WIDTH-1:INDEX_BITS+2], update_pc[1:0]};

  // History is zero-extended to the index width so the XOR stays in range.
  // Updates hash with the checkpointed history, never the live GHR, so they
  // hit the same entry the original lookup read.
  always_comb begin
    lookup_hist = '0;
    update_hist = '0;
    if (MODE == 1) begin
      lookup_hist[GHR_BITS-1:0] = ghr_q;
      update_hist[GHR_BITS-1:0] = update_ghr;
    end
  end

  assign lookup_idx = lookup_pc_idx ^ lookup_hist;
  assign update_idx = update_pc_idx ^ update_hist;
  assign lookup_ctr = table_q[lookup_idx];
  assign update_ctr = table_q[update_idx];

  assign do_update = update_valid && is_branch;
  assign recover   = do_update && mispredict;

  // Shift-left-and-insert; the width cast drops the oldest bit and also
  // covers the single-bit history case.
  assign spec_ghr    = GHR_BITS'({ghr_q, lookup_ctr[CTR_BITS-1]});
  assign recover_ghr = GHR_BITS'({update_ghr, actual_taken});

  assign prediction       = lookup_ctr[CTR_BITS-1];
  assign confidence       = lookup_ctr;
  assign pred_ghr         = ghr_q;
  assign ghr_out          = ghr_q;
  assign mispredict_count = mis_count_q;

  // Counter table: saturating increment on taken, decrement on not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= CTR_INIT;
      end
    end else if (do_update) begin
      if (actual_taken) begin
        if (update_ctr != CTR_MAX) begin
          table_q[update_idx] <= update_ctr + CTR_BITS'(1);
        end
      end else begin
        if (update_ctr != '0) begin
          table_q[update_idx] <= update_ctr - CTR_BITS'(1);
        end
      end
    end
  end

  // GHR: a mispredict restore wins over a same-cycle speculative shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghr_q <= '0;
    end else if (recover) begin
      ghr_q <= recover_ghr;
    end else if (predict_valid) begin
      ghr_q <= spec_ghr;
    end
  end

  // Mispredict statistics, pinned at all-ones once full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mis_count_q <= '0;
    end else if (recover && (mis_count_q != STAT_MAX)) begin
      mis_count_q <= mis_count_q + STAT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_gshare_bht.sv
// tb_gshare_bht: self-checking bench for gshare_bht (INDEX_BITS=8, GHR_BITS=4,
// CTR_BITS=2, gshare mode). A second instance with a 2-bit statistics counter
// shares the stimulus so counter saturation is reachable in a few cycles.
module tb_gshare_bht;

  localparam int K_PRED  = 0;
  localparam int K_CONF  = 1;
  localparam int K_PGHR  = 2;
  localparam int K_GHR   = 3;
  localparam int K_CNT   = 4;
  localparam int K_CNT2  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        predict_valid = 1'b0;
  logic [31:0] predict_pc = '0;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic [3:0]  update_ghr = '0;
  logic        actual_taken = 1'b0;
  logic        is_branch = 1'b0;
  logic        mispredict = 1'b0;

  logic        prediction;
  logic [1:0]  confidence;
  logic [3:0]  pred_ghr;
  logic [3:0]  ghr_out;
  logic [15:0] mispredict_count;

  logic        prediction2;
  logic [1:0]  confidence2;
  logic [3:0]  pred_ghr2;
  logic [3:0]  ghr_out2;
  logic [1:0]  mispredict_count2;

  int checks = 0;
  int errors = 0;

  int          kind_q[$];
  logic [31:0] val_q[$];
  string       tag_q[$];

  logic [1:0]  m_tab [256];
  logic [3:0]  m_ghr;
  int          m_cnt;
  int          m_cnt2;

  gshare_bht #(
    .ADDR_WIDTH(32), .INDEX_BITS(8), .GHR_BITS(4), .CTR_BITS(2), .MODE(1), .STAT_BITS(16)
  ) dut (
    .clk(clk), .reset(reset),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .prediction(prediction), .confidence(confidence), .pred_ghr(pred_ghr),
    .update_valid(update_valid), .update_pc(update_pc), .update_ghr(update_ghr),
    .actual_taken(actual_taken), .is_branch(is_branch), .mispredict(mispredict),
    .ghr_out(ghr_out), .mispredict_count(mispredict_count)
  );

  gshare_bht #(
    .ADDR_WIDTH(32), .INDEX_BITS(8), .GHR_BITS(4), .CTR_BITS(2), .MODE(1), .STAT_BITS(2)
  ) dut_stat (
    .clk(clk), .reset(reset),
    .predict_valid(predict_valid), .predict_pc(predict_pc),
    .prediction(prediction2), .confidence(confidence2), .pred_ghr(pred_ghr2),
    .update_valid(update_valid), .update_pc(update_pc), .update_ghr(update_ghr),
    .actual_taken(actual_taken), .is_branch(is_branch), .mispredict(mispredict),
    .ghr_out(ghr_out2), .mispredict_count(mispredict_count2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic expectValue(input int kind, input logic [31:0] val, input string tag);
    kind_q.push_back(kind);
    val_q.push_back(val);
    tag_q.push_back(tag);
  endtask

  task automatic drainScoreboard();
    int          k;
    logic [31:0] v;
    logic [31:0] obs;
    string       t;
    while (kind_q.size() > 0) begin
      k = kind_q.pop_front();
      v = val_q.pop_front();
      t = tag_q.pop_front();
      case (k)
        K_PRED:  obs = 32'(prediction);
        K_CONF:  obs = 32'(confidence);
        K_PGHR:  obs = 32'(pred_ghr);
        K_GHR:   obs = 32'(ghr_out);
        K_CNT:   obs = 32'(mispredict_count);
        K_CNT2:  obs = 32'(mispredict_count2);
        default: obs = 'x;
      endcase
      checkOutput(t, obs, v);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) m_tab[i] = 2'b01;
    m_ghr  = '0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  // One clock of stimulus: lookup outputs are checked before the edge,
  // state outputs after it, both against the reference model.
  task automatic applyStimulus(input logic pv, input logic [31:0] ppc,
                               input logic uv, input logic [31:0] upc,
                               input logic [3:0] ughr, input logic taken,
                               input logic isb, input logic mis);
    logic [7:0] lidx;
    logic [7:0] uidx;
    logic [1:0] lctr;
    predict_valid = pv;
    predict_pc    = ppc;
    update_valid  = uv;
    update_pc     = upc;
    update_ghr    = ughr;
    actual_taken  = taken;
    is_branch     = isb;
    mispredict    = mis;
    lidx = ppc[9:2] ^ {4'b0000, m_ghr};
    lctr = m_tab[lidx];
    expectValue(K_PRED, 32'(lctr[1]), "prediction");
    expectValue(K_CONF, 32'(lctr), "confidence");
    expectValue(K_PGHR, 32'(m_ghr), "pred_ghr");
    #1;
    drainScoreboard();
    if (uv && isb && mis) m_ghr = {ughr[2:0], taken};
    else if (pv)          m_ghr = {m_ghr[2:0], lctr[1]};
    if (uv && isb) begin
      uidx = upc[9:2] ^ {4'b0000, ughr};
      if (taken && m_tab[uidx] != 2'b11)       m_tab[uidx] = m_tab[uidx] + 2'd1;
      else if (!taken && m_tab[uidx] != 2'b00) m_tab[uidx] = m_tab[uidx] - 2'd1;
      if (mis) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3)    m_cnt2++;
      end
    end
    @(posedge clk);
    #1;
    predict_valid = 1'b0;
    update_valid  = 1'b0;
    expectValue(K_GHR,  32'(m_ghr),  "ghr_out");
    expectValue(K_CNT,  32'(m_cnt),  "mispredict_count");
    expectValue(K_CNT2, 32'(m_cnt2), "mispredict_count_sat");
    drainScoreboard();
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] upc_r;

    // Reset held from the start: outputs show the reset image.
    #1 reset = 1'b0;
    predict_pc = 32'h40;
    #2;
    checkOutput("rst_held_prediction", 32'(prediction), 32'h0);
    checkOutput("rst_held_confidence", 32'(confidence), 32'h1);
    checkOutput("rst_held_pred_ghr",   32'(pred_ghr),   32'h0);
    checkOutput("rst_held_ghr_out",    32'(ghr_out),    32'h0);
    checkOutput("rst_held_count",      32'(mispredict_count), 32'h0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Released: weak not-taken at index 0x10.
    expectValue(K_PRED, 32'h0, "reset_prediction");
    expectValue(K_CONF, 32'h1, "reset_confidence");
    expectValue(K_GHR,  32'h0, "reset_ghr_out");
    expectValue(K_CNT,  32'h0, "reset_count");
    applyStimulus(1'b0, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Train index 0x10 twice towards taken, then look it up speculatively.
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b1, 1'b0);
    expectValue(K_PRED, 32'h1, "trained_prediction");
    expectValue(K_CONF, 32'h3, "trained_confidence");
    expectValue(K_PGHR, 32'h0, "trained_pred_ghr");
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("ghr_after_train", 32'(ghr_out), 32'h1);

    // History 0001 steers pc 0x40 to index 0x11, still untrained.
    expectValue(K_CONF, 32'h1, "gshare_separation");
    applyStimulus(1'b0, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Build GHR 1011 by shifting in 0, 1, 1 (pcs chosen to hit 0x11, 0x10, 0x10).
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h48, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h54, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("ghr_before_recovery", 32'(ghr_out), 32'hB);

    // Recovery beats the simultaneous speculative shift.
    applyStimulus(1'b1, 32'h54, 1'b1, 32'h40, 4'h2, 1'b1, 1'b1, 1'b1);
    checkOutput("ghr_after_recovery",   32'(ghr_out), 32'h5);
    checkOutput("count_after_recovery", 32'(mispredict_count), 32'h1);

    // Saturation at index 0x10 (pc 0x54 with GHR 0101 reads it).
    expectValue(K_CONF, 32'h3, "sat_down_start");
    applyStimulus(1'b0, 32'h54, 1'b1, 32'h40, 4'h0, 1'b0, 1'b1, 1'b0);
    expectValue(K_CONF, 32'h2, "sat_down_1");
    applyStimulus(1'b0, 32'h54, 1'b1, 32'h40, 4'h0, 1'b0, 1'b1, 1'b0);
    expectValue(K_CONF, 32'h1, "sat_down_2");
    applyStimulus(1'b0, 32'h54, 1'b1, 32'h40, 4'h0, 1'b0, 1'b1, 1'b0);
    expectValue(K_CONF, 32'h0, "sat_down_3");
    applyStimulus(1'b0, 32'h54, 1'b1, 32'h40, 4'h0, 1'b0, 1'b1, 1'b0);
    expectValue(K_CONF, 32'h0, "sat_floor");
    applyStimulus(1'b0, 32'h54, 1'b1, 32'h40, 4'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h54, 1'b1, 32'h40, 4'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h54, 1'b1, 32'h40, 4'h0, 1'b1, 1'b1, 1'b0);
    expectValue(K_CONF, 32'h3, "sat_up_top");
    applyStimulus(1'b0, 32'h54, 1'b1, 32'h40, 4'h0, 1'b1, 1'b1, 1'b0);
    expectValue(K_CONF, 32'h3, "sat_ceiling");
    applyStimulus(1'b0, 32'h54, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    // Statistics saturation on the 2-bit instance.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h80, 1'b1, 32'h80, 4'h0, 1'b0, 1'b1, 1'b1);
    end
    checkOutput("count_sat_small", 32'(mispredict_count2), 32'h3);
    checkOutput("count_wide",      32'(mispredict_count),  32'h4);

    // Non-branch update must leave everything untouched.
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("non_branch_count", 32'(mispredict_count), 32'h4);

    // Randomised traffic with aliasing upper/lower PC bits.
    for (int i = 0; i < 300; i++) begin
      rpc   = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      upc_r = ($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 15)) << 2);
      applyStimulus(1'($urandom_range(0, 1)), rpc,
                    ($urandom_range(0, 9) < 7), upc_r, 4'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8),
                    ($urandom_range(0, 3) == 0));
    end

    // Mid-operation reset: train 0x10, set GHR 0110, then drop reset between edges.
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h40, 4'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h40, 4'h3, 1'b0, 1'b1, 1'b1);
    checkOutput("ghr_before_midreset", 32'(ghr_out), 32'h6);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midreset_ghr_out",    32'(ghr_out),    32'h0);
    checkOutput("midreset_pred_ghr",   32'(pred_ghr),   32'h0);
    checkOutput("midreset_confidence", 32'(confidence), 32'h1);
    checkOutput("midreset_prediction", 32'(prediction), 32'h0);
    checkOutput("midreset_count",      32'(mispredict_count), 32'h0);
    predict_valid = 1'b1;
    update_valid  = 1'b1;
    update_pc     = 32'h40;
    update_ghr    = 4'h0;
    actual_taken  = 1'b1;
    is_branch     = 1'b1;
    mispredict    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("held_ghr_out",    32'(ghr_out),    32'h0);
    checkOutput("held_confidence", 32'(confidence), 32'h1);
    checkOutput("held_count",      32'(mispredict_count), 32'h0);
    @(negedge clk);
    predict_valid = 1'b0;
    update_valid  = 1'b0;
    reset = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    expectValue(K_CONF, 32'h1, "post_reset_confidence");
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h44, 4'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_bht.md
Name: gshare_bht

Overview:
- Parametrised successor to the 2-bit bimodal branch history table.
- Configurable counter width and index width; optional global-history (gshare) indexing with a speculative global history register (GHR); mispredict recovery from a checkpoint; saturating mispredict statistics counter.
- Sits in the IFU next to the BTB. Fetch stage looks up; execute/commit stage updates and recovers.

Parameters:
- ADDR_WIDTH, 32, PC width.
- INDEX_BITS, 8, table index width; table depth = 2**INDEX_BITS.
- GHR_BITS, 8, global history length; legal range 1..INDEX_BITS.
- CTR_BITS, 2, saturating counter width; legal range 2..4.
- MODE, 1, 0 = bimodal (PC index only), 1 = gshare (PC index XOR GHR).
- STAT_BITS, 16, mispredict counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- predict_valid  in  1  fetch presents a branch for prediction; GHR shifts speculatively.
- predict_pc  in  ADDR_WIDTH  PC to predict.
- prediction  out  1  1 = taken.
- confidence  out  CTR_BITS  raw counter at the lookup index.
- pred_ghr  out  GHR_BITS  GHR used for this lookup; pipeline carries it as a checkpoint.
- update_valid  in  1  update strobe.
- update_pc  in  ADDR_WIDTH  resolved branch PC.
- update_ghr  in  GHR_BITS  checkpoint captured at prediction time.
- actual_taken  in  1  resolved outcome.
- is_branch  in  1  update qualifier.
- mispredict  in  1  resolved direction differed from prediction.
- ghr_out  out  GHR_BITS  current GHR (debug).
- mispredict_count  out  STAT_BITS  saturating mispredict count.

Behaviour:
- Index:
  - pc_idx = pc[INDEX_BITS+1:2].
  - MODE=1: idx = pc_idx XOR zero-extended history.
  - MODE=0: idx = pc_idx.
  - Lookup uses the current GHR. Update uses update_ghr, never the live GHR.
- Lookup:
  - Combinational, zero latency.
  - prediction = counter MSB; confidence = counter value; pred_ghr = GHR.
  - Same-cycle write to the same index is not forwarded; lookup returns the pre-edge value.
- Counter update:
  - Occurs on posedge when update_valid && is_branch.
  - If taken: increment, saturating at 2**CTR_BITS-1.
  - Else: decrement, saturating at 0.
  - update_valid && !is_branch: no state change anywhere.
- GHR, priority per posedge:
  - 1) update_valid && is_branch && mispredict: GHR <= {update_ghr[GHR_BITS-2:0], actual_taken}. For GHR_BITS=1: GHR <= actual_taken.
  - 2) else predict_valid: GHR <= {GHR[GHR_BITS-2:0], prediction}.
  - 3) else hold.
  - Recovery overrides a simultaneous speculative shift.
  - In MODE=0 the GHR is still maintained but not used for indexing.
- mispredict_count:
  - Increments on update_valid && is_branch && mispredict.
  - Saturates at all-ones; never wraps.
- Reset (reset low, asynchronous, takes effect immediately, including mid-operation):
  - Every counter = 2**(CTR_BITS-1)-1 (weak not-taken; 2'b01 for CTR_BITS=2).
  - GHR = 0, mispredict_count = 0.
  - Outputs while held: prediction 0, confidence 2**(CTR_BITS-1)-1, pred_ghr 0, ghr_out 0, mispredict_count 0.
  - No update takes effect while reset is low.
- Wrap-around:
  - Index bits above INDEX_BITS+1 are ignored; aliasing is permitted.
  - XOR never exceeds table depth.

Test Plan:
(Config for all scenarios: INDEX_BITS=8, GHR_BITS=4, CTR_BITS=2, MODE=1, STAT_BITS=16.)
- Reset: release reset, predict_pc=0x40 -> prediction=0, confidence=2'b01, ghr_out=4'b0000, mispredict_count=0.
- Training: two updates pc=0x40, update_ghr=0, taken=1 -> index 0x10 goes 01->10->11. Then predict_valid pc=0x40 -> prediction=1, confidence=2'b11, pred_ghr=0; next cycle ghr_out=4'b0001.
- Gshare separation: with ghr_out=4'b0001, lookup pc=0x40 reads index 0x11 -> confidence=2'b01, independent of index 0x10.
- Recovery priority: GHR=4'b1011; same cycle predict_valid=1 and mispredict update with update_ghr=4'b0010, taken=1 -> ghr_out=4'b0101; mispredict_count=1.
- Saturation: index 0x10 at 11; three not-taken updates -> 10, 01, 00; fourth -> stays 00. Taken update at 11 stays 11. mispredict_count preloaded to 0xFFFF plus one more mispredict -> stays 0xFFFF.
- Reset mid-operation: trained table, GHR=4'b0110; pull reset low between edges -> ghr_out=0 and confidence=2'b01 before next edge; update_valid pulses during reset have no effect.
